// File: rtl/jstk_spi_slave_pkg.sv
// Shared definitions for the PmodJSTK SPI slave emulator.
package jstk_spi_slave_pkg;

  localparam int unsigned JSTK_FRAME_BYTES = 5;
  localparam logic [5:0]  JSTK_LED_CMD_HDR = 6'b100000;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } jstk_state_e;

  // Response byte for a given frame position; positions past the payload read 0x00.
  function automatic logic [7:0] jstk_tx_byte(input logic [2:0] idx,
                                              input logic [9:0] x,
                                              input logic [9:0] y,
                                              input logic [2:0] btns);
    logic [7:0] b;
    b = '0;
    case (idx)
      3'd0:    b = x[7:0];
      3'd1:    b = {6'b0, x[9:8]};
      3'd2:    b = y[7:0];
      3'd3:    b = {6'b0, y[9:8]};
      3'd4:    b = {5'b0, btns};
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jstk_spi_slave_if.sv
// SPI pins plus joystick/LED side-band signals of the JSTK slave.
interface jstk_spi_slave_if;
  logic       SS;
  logic       SCLK;
  logic       MOSI;
  logic       MISO;
  logic [9:0] X_POS;
  logic [9:0] Y_POS;
  logic [2:0] BTNS;
  logic [1:0] LED;
  logic       CMD_VALID;
  logic       FRAME_DONE;
  logic       BUSY;

  modport slave (
    input  SS, SCLK, MOSI, X_POS, Y_POS, BTNS,
    output MISO, LED, CMD_VALID, FRAME_DONE, BUSY
  );

  modport master (
    output SS, SCLK, MOSI, X_POS, Y_POS, BTNS,
    input  MISO, LED, CMD_VALID, FRAME_DONE, BUSY
  );
endinterface

// File: rtl/jstk_spi_slave_sync_edge.sv
// Multi-flop synchroniser with single-cycle rise/fall pulses.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Shift the async input through the chain; keep one extra delayed copy for edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/jstk_spi_slave.sv
// SPI mode-0 slave emulating the PmodJSTK: returns X/Y/buttons, accepts LED commands.
module jstk_spi_slave
  import jstk_spi_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BYTES = JSTK_FRAME_BYTES
) (
  input  logic            CLK,
  input  logic            RST,
  jstk_spi_slave_if.slave bus
);

  localparam logic [2:0] FB = 3'(FRAME_BYTES);

  logic ss_s, ss_rise, ss_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk_i(CLK), .rst_i(RST), .d_i(bus.SS),
    .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk_i(CLK), .rst_i(RST), .d_i(bus.SCLK),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk_i(CLK), .rst_i(RST), .d_i(bus.MOSI),
    .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall};

  jstk_state_e state_q;
  logic [9:0]  x_q, y_q;
  logic [2:0]  btns_q;
  logic [7:0]  tx_q, rx_q, rx_d;
  logic [2:0]  bit_q, bit_d, byte_q, byte_d;
  logic [7:0]  tx_load_d, tx_first_d;
  logic        miso_q, cmd_q, done_q, busy_q;
  logic [1:0]  led_q;
  logic        sclk_r, sclk_f;

  // SCLK edges only count while SS is low.
  assign sclk_r = sclk_rise & ~ss_s;
  assign sclk_f = sclk_fall & ~ss_s;

  // Next values for the rx shifter, counters and tx byte selection.
  always_comb begin
    rx_d       = {rx_q[6:0], mosi_s};
    bit_d      = bit_q + 3'd1;
    byte_d     = (bit_q == 3'd7 && byte_q < FB) ? byte_q + 3'd1 : byte_q;
    tx_load_d  = (byte_q >= FB) ? '0 : jstk_tx_byte(byte_q, x_q, y_q, btns_q);
    tx_first_d = jstk_tx_byte(3'd0, bus.X_POS, bus.Y_POS, bus.BTNS);
  end

  // Frame FSM with counters, shifters and registered outputs; SS edges take priority over SCLK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      btns_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      miso_q  <= 1'b0;
      led_q   <= '0;
      cmd_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cmd_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (ss_fall) begin
            state_q <= ACTIVE;
            x_q     <= bus.X_POS;
            y_q     <= bus.Y_POS;
            btns_q  <= bus.BTNS;
            tx_q    <= tx_first_d;
            miso_q  <= tx_first_d[7];
            bit_q   <= '0;
            byte_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
            done_q  <= (byte_q >= FB) && (bit_q == 3'd0);
            bit_q   <= '0;
            byte_q  <= '0;
          end else if (sclk_r) begin
            rx_q   <= rx_d;
            bit_q  <= bit_d;
            byte_q <= byte_d;
            if (bit_q == 3'd7 && byte_q == 3'd0 && rx_d[7:2] == JSTK_LED_CMD_HDR) begin
              led_q <= rx_d[1:0];
              cmd_q <= 1'b1;
            end
          end else if (sclk_f) begin
            if (bit_q != 3'd0) begin
              tx_q   <= {tx_q[6:0], 1'b0};
              miso_q <= tx_q[6];
            end else begin
              tx_q   <= tx_load_d;
              miso_q <= tx_load_d[7];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.MISO       = miso_q;
  assign bus.LED        = led_q;
  assign bus.CMD_VALID  = cmd_q;
  assign bus.FRAME_DONE = done_q;
  assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_jstk_spi_slave.sv
// Self-checking bench for jstk_spi_slave: directed scenarios plus randomized frames.
module tb_jstk_spi_slave;

  localparam int unsigned HALF = 10;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  jstk_spi_slave_if bus();

  jstk_spi_slave #(.SYNC_STAGES(2), .FRAME_BYTES(5)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cmd_pulses = 0;
  int done_pulses = 0;

  logic [7:0] mosi_buf [8];
  logic [7:0] miso_got [8];
  logic [1:0] led_m = 2'b00;

  always @(posedge CLK) begin
    if (bus.CMD_VALID === 1'b1) cmd_pulses++;
    if (bus.FRAME_DONE === 1'b1) done_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference response: X low/high, Y low/high, buttons, then zeros.
  function automatic logic [7:0] exp_byte(input int unsigned k, input int unsigned x,
                                          input int unsigned y, input int unsigned b);
    case (k)
      0:       return 8'(x % 256);
      1:       return 8'(x / 256);
      2:       return 8'(y % 256);
      3:       return 8'(y / 256);
      4:       return 8'(b);
      default: return 8'h00;
    endcase
  endfunction

  task automatic run_frame(input string name, input int unsigned nbits,
                           input bit flip_x, input int rst_at);
    int unsigned x0, y0, b0, whole;
    int c0, d0, exp_cmd, exp_done;
    x0 = 32'(bus.X_POS);
    y0 = 32'(bus.Y_POS);
    b0 = 32'(bus.BTNS);
    c0 = cmd_pulses;
    d0 = done_pulses;
    for (int k = 0; k < 8; k++) miso_got[k] = '0;
    @(negedge CLK);
    bus.SS   = 1'b0;
    bus.MOSI = mosi_buf[0][7];
    repeat (HALF) @(negedge CLK);
    check({name, " busy"}, 32'(bus.BUSY), 32'd1);
    for (int unsigned i = 0; i < nbits; i++) begin
      if (int'(i) == rst_at) begin
        RST      = 1'b1;
        bus.SS   = 1'b1;
        bus.SCLK = 1'b0;
        bus.MOSI = 1'b0;
        led_m    = 2'b00;
        repeat (3) @(negedge CLK);
        check({name, " rst miso"}, 32'(bus.MISO), 32'd0);
        check({name, " rst led"}, 32'(bus.LED), 32'd0);
        check({name, " rst cmd"}, 32'(bus.CMD_VALID), 32'd0);
        check({name, " rst done"}, 32'(bus.FRAME_DONE), 32'd0);
        check({name, " rst busy"}, 32'(bus.BUSY), 32'd0);
        RST = 1'b0;
        repeat (2 * HALF) @(negedge CLK);
        return;
      end
      miso_got[i / 8][7 - (i % 8)] = bus.MISO;
      if (flip_x && i == 12) bus.X_POS = ~bus.X_POS;
      bus.SCLK = 1'b1;
      repeat (HALF) @(negedge CLK);
      bus.SCLK = 1'b0;
      if (i + 1 < nbits) bus.MOSI = mosi_buf[(i + 1) / 8][7 - ((i + 1) % 8)];
      repeat (HALF) @(negedge CLK);
    end
    bus.SS = 1'b1;
    repeat (2 * HALF) @(negedge CLK);

    whole = nbits / 8;
    for (int unsigned k = 0; k < whole && k < 8; k++)
      check($sformatf("%s byte%0d", name, k), 32'(miso_got[k]), 32'(exp_byte(k, x0, y0, b0)));
    exp_cmd = (nbits >= 8 && mosi_buf[0][7:2] == 6'b100000) ? 1 : 0;
    if (exp_cmd == 1) led_m = mosi_buf[0][1:0];
    exp_done = (nbits % 8 == 0 && whole >= 5) ? 1 : 0;
    check({name, " cmd pulses"}, 32'(cmd_pulses - c0), 32'(exp_cmd));
    check({name, " led"}, 32'(bus.LED), 32'(led_m));
    check({name, " done pulses"}, 32'(done_pulses - d0), 32'(exp_done));
    check({name, " idle busy"}, 32'(bus.BUSY), 32'd0);
    check({name, " idle miso"}, 32'(bus.MISO), 32'd0);
  endtask

  task automatic set_mosi(input logic [7:0] b0);
    mosi_buf[0] = b0;
    for (int k = 1; k < 8; k++) mosi_buf[k] = 8'($urandom);
  endtask

  initial begin
    bus.SS    = 1'b1;
    bus.SCLK  = 1'b0;
    bus.MOSI  = 1'b0;
    bus.X_POS = '0;
    bus.Y_POS = '0;
    bus.BTNS  = '0;
    for (int k = 0; k < 8; k++) mosi_buf[k] = '0;
    repeat (5) @(negedge CLK);
    check("reset miso", 32'(bus.MISO), 32'd0);
    check("reset led", 32'(bus.LED), 32'd0);
    check("reset cmd", 32'(bus.CMD_VALID), 32'd0);
    check("reset done", 32'(bus.FRAME_DONE), 32'd0);
    check("reset busy", 32'(bus.BUSY), 32'd0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    // Reference frame with LED command 0x83.
    bus.X_POS = 10'h2A5; bus.Y_POS = 10'h0F3; bus.BTNS = 3'b101;
    for (int k = 0; k < 8; k++) mosi_buf[k] = '0;
    mosi_buf[0] = 8'h83;
    run_frame("t1", 40, 1'b0, -1);

    // Non-command byte 0 leaves LED alone.
    bus.X_POS = 10'($urandom); bus.Y_POS = 10'($urandom); bus.BTNS = 3'($urandom);
    set_mosi(8'h40);
    run_frame("t2", 40, 1'b0, -1);

    // Aborted partial frame, then a full one.
    set_mosi(8'h81);
    run_frame("t3a", 20, 1'b0, -1);
    bus.X_POS = 10'($urandom); bus.Y_POS = 10'($urandom); bus.BTNS = 3'($urandom);
    set_mosi(8'h00);
    run_frame("t3b", 40, 1'b0, -1);

    // Over-long frame reads zeros past the payload.
    bus.X_POS = 10'($urandom); bus.Y_POS = 10'($urandom); bus.BTNS = 3'($urandom);
    set_mosi(8'h82);
    run_frame("t4", 56, 1'b0, -1);

    // X changes mid-frame; response must use the snapshot.
    bus.X_POS = 10'($urandom); bus.Y_POS = 10'($urandom);
    set_mosi(8'h13);
    run_frame("t5", 40, 1'b1, -1);

    // Reset mid-byte, then a frame with no command keeps LED at 00.
    set_mosi(8'h83);
    run_frame("t6a", 40, 1'b0, 13);
    bus.X_POS = 10'($urandom); bus.Y_POS = 10'($urandom); bus.BTNS = 3'($urandom);
    set_mosi(8'h7F);
    run_frame("t6b", 40, 1'b0, -1);

    // Randomized frames.
    for (int n = 0; n < 8; n++) begin
      logic [7:0] b0r;
      int unsigned nb;
      bus.X_POS = 10'($urandom); bus.Y_POS = 10'($urandom); bus.BTNS = 3'($urandom);
      b0r = 8'($urandom);
      if ($urandom_range(1, 0) == 1) b0r[7:2] = 6'b100000;
      set_mosi(b0r);
      case ($urandom_range(3, 0))
        0:       nb = $urandom_range(39, 1);
        1:       nb = 48;
        default: nb = 40;
      endcase
      run_frame($sformatf("rnd%0d", n), nb, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
